// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and sizes for the LM/SM multi-register transfer sequencer.
package lm_sm_sequencer_pkg;
  localparam int WORD_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;
endpackage

// File: rtl/lm_sm_sequencer_pri_enc_8to3.sv
// Lowest-set-bit priority encoder: idx points at the lowest set bit of in_vec.
module pri_enc_8to3
  import lm_sm_sequencer_pkg::*;
(
  input  logic [NUM_REGS-1:0]  in_vec,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 any
);
  always_comb begin
    idx = '0;
    any = |in_vec;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (in_vec[i]) idx = i[REG_IDX_W-1:0];
    end
  end
endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask in ascending order, one register
// per cycle, issuing consecutive word addresses starting at base_addr.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [NUM_REGS-1:0]  mask,
  input  logic [WORD_W-1:0]    base_addr,
  input  logic                 hold,
  input  logic                 flush,
  output logic [REG_IDX_W-1:0] reg_sel,
  output logic [WORD_W-1:0]    mem_addr,
  output logic                 valid,
  output logic                 rf_we,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 stall_req,
  output logic                 done
);
  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] rem_mask_q, rem_mask_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic                st_q, st_d;

  logic [REG_IDX_W-1:0] enc_idx;
  logic                 enc_any;
  logic                 multi;

  pri_enc_8to3 u_pri_enc (
    .in_vec (rem_mask_q),
    .idx    (enc_idx),
    .any    (enc_any)
  );

  always_comb begin
    // x & (x-1) is nonzero exactly when two or more bits remain.
    multi     = |(rem_mask_q & (rem_mask_q - NUM_REGS'(1)));
    busy      = (state_q == XFER);
    valid     = busy & enc_any & ~hold & ~flush;
    done      = busy & ~multi & ~hold & ~flush;
    rf_we     = valid & ~st_q;
    mem_we    = valid & st_q;
    stall_req = busy & ~done;
    reg_sel   = busy ? enc_idx : '0;
    mem_addr  = addr_q;
  end

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    addr_d     = addr_q;
    st_d       = st_q;
    if (flush) begin
      state_d    = IDLE;
      rem_mask_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = XFER;
            rem_mask_d = mask;
            addr_d     = base_addr;
            st_d       = is_store;
          end
        end
        XFER: begin
          if (valid) begin
            rem_mask_d = rem_mask_q & ~(NUM_REGS'(1) << enc_idx);
            addr_d     = addr_q + WORD_W'(1);
          end
          if (done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_mask_q <= '0;
      addr_q     <= '0;
      st_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      addr_q     <= addr_d;
      st_q       <= st_d;
    end
  end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: expected transfers are queued at
// start and retired by a negedge monitor whenever the DUT asserts valid.
module tb_lm_sm_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store, hold, flush;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic [2:0]  reg_sel;
  logic [15:0] mem_addr;
  logic        valid, rf_we, mem_we, busy, stall_req, done;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] addr;
    logic        st;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .mask(mask), .base_addr(base_addr), .hold(hold), .flush(flush),
    .reg_sel(reg_sel), .mem_addr(mem_addr), .valid(valid), .rf_we(rf_we),
    .mem_we(mem_we), .busy(busy), .stall_req(stall_req), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},  32'(reg_sel), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_ctl"},  32'({valid, rf_we, mem_we, busy, stall_req, done}), 0);
  endtask

  // Monitor: every valid cycle retires the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(reg_sel), 32'hDEAD);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("reg_sel",  32'(reg_sel), 32'(e.sel));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_we",   32'(mem_we), 32'(e.st));
        chk("rf_we",    32'(rf_we), 32'(!e.st));
      end
    end
  end

  // Runs one LM/SM sequence. hold_k / flush_k name the busy cycle (1-based)
  // in which hold / flush is raised; 0 means never.
  task automatic run_seq(input string tag, input logic st, input logic [7:0] m,
                         input logic [15:0] base, input int hold_k, input int flush_k,
                         input int exp_busy, input int exp_done);
    int n, lim, nbusy, ndone, last_done;
    logic [15:0] a;
    xfer_t e;
    n = 0; a = base;
    lim = 8;
    if (flush_k > 0) lim = flush_k - 1 - ((hold_k > 0 && hold_k < flush_k) ? 1 : 0);
    for (int i = 0; i < 8; i++) begin
      if (m[i] && n < lim) begin
        e.sel = 3'(i); e.addr = a; e.st = st;
        exp_q.push_back(e);
        a = a + 16'd1;
        n++;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; is_store = st; mask = m; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; mask = 8'h00; base_addr = 16'h0;
    nbusy = 0; ndone = 0; last_done = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      hold  = (cyc == hold_k);
      flush = (cyc == flush_k);
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      if (done) begin ndone++; last_done = cyc; end
      if (cyc == hold_k) begin
        chk({tag, "_hold_vld"}, 32'({valid, done}), 0);
        if (exp_q.size() > 0) begin
          chk({tag, "_hold_sel"},  32'(reg_sel), 32'(exp_q[0].sel));
          chk({tag, "_hold_addr"}, 32'(mem_addr), 32'(exp_q[0].addr));
        end
      end
      if (cyc == flush_k) chk({tag, "_flush"}, 32'({valid, done, stall_req}), 32'b001);
      chk({tag, "_stall"}, 32'(stall_req), 32'(!done));
      if (cyc == 40) chk({tag, "_timeout"}, 32'(busy), 0);
      @(posedge clk); #1;
    end
    hold = 1'b0; flush = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    chk({tag, "_done_cnt"}, 32'(ndone), 32'(exp_done));
    if (exp_done > 0) chk({tag, "_done_last"}, 32'(last_done), 32'(exp_busy));
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    xfer_t e;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; hold = 1'b0; flush = 1'b0;
    mask = 8'h00; base_addr = 16'h0;
    #3;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // SM ascending walk, done on third transfer
    run_seq("sm_85", 1'b1, 8'b1000_0101, 16'h0100, 0, 0, 3, 1);
    // zero mask: one busy cycle with done only
    run_seq("lm_00", 1'b0, 8'h00, 16'h0040, 0, 0, 1, 1);
    // hold during second transfer cycle
    run_seq("lm_hold", 1'b0, 8'h0F, 16'h0010, 2, 0, 5, 1);
    // address wrap
    run_seq("sm_wrap", 1'b1, 8'h03, 16'hFFFF, 0, 0, 2, 1);
    // flush on third transfer cycle, then a fresh start
    run_seq("lm_flush", 1'b0, 8'hFF, 16'h0300, 0, 3, 3, 0);
    run_seq("sm_after", 1'b1, 8'h90, 16'h1234, 0, 0, 2, 1);

    // Mid-sequence reset; a start pulsed while busy must be ignored.
    e.st = 1'b0;
    e.sel = 3'd4; e.addr = 16'h0200; exp_q.push_back(e);
    e.sel = 3'd5; e.addr = 16'h0201; exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; mask = 8'hF0; base_addr = 16'h0200;
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; mask = 8'h01; base_addr = 16'h0999;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_sel", 32'(reg_sel), 32'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    chk("mid_reset_q", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    run_seq("post_rst", 1'b0, 8'h41, 16'h0020, 0, 0, 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
